// File: rtl/shift_reg_seq_if.sv
// Operand/result bundle for the shift/rotate unit.
// The master side drives the request and operand; the slave side returns the
// working register and its status flags.
interface shift_reg_seq_if #(
    parameter int WIDTH = 16
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             carry;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, amt, din,
        input  dout, carry, busy, done
    );

    modport slave (
        input  start, mode, amt, din,
        output dout, carry, busy, done
    );
endinterface

// File: rtl/shift_reg_seq.sv
// Multi-cycle shift/rotate unit.
// Loads a word, then shifts or rotates it by one bit position per clock for
// the requested amount. A one-cycle done pulse marks the result. Mode,
// amount and operand are captured at the accept edge and stay frozen until
// the operation ends.
module shift_reg_seq #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_reg_seq_if.slave bus
);
    localparam int AMT_W = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] ONE = AMT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Mode encodings. Codes 101-111 fall through to the default branch (HOLD).
    typedef enum logic [2:0] {
        OP_LSL = 3'b000,
        OP_LSR = 3'b001,
        OP_ASR = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_t;

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] data_q,  data_nxt;
    logic             carry_q, carry_nxt;
    logic [AMT_W-1:0] count_q, count_nxt;
    logic [2:0]       mode_q,  mode_nxt;

    // Next-state and datapath: accept a request, or step the shift by one bit.
    always_comb begin
        // NOTE: every variable gets a default before any branch. A path that
        // leaves one of them unassigned would infer a latch.
        state_nxt = state_q;
        data_nxt  = data_q;
        carry_nxt = carry_q;
        count_nxt = count_q;
        mode_nxt  = mode_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    data_nxt  = bus.din;
                    mode_nxt  = bus.mode;
                    count_nxt = bus.amt;
                    carry_nxt = 1'b0;
                    state_nxt = (bus.amt != '0) ? SHIFT : DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                case (mode_q)
                    OP_LSL: begin
                        data_nxt  = {data_q[WIDTH-2:0], 1'b0};
                        carry_nxt = data_q[WIDTH-1];
                    end
                    OP_LSR: begin
                        data_nxt  = {1'b0, data_q[WIDTH-1:1]};
                        carry_nxt = data_q[0];
                    end
                    OP_ASR: begin
                        data_nxt  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                        carry_nxt = data_q[0];
                    end
                    OP_ROL: begin
                        data_nxt  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                        carry_nxt = data_q[WIDTH-1];
                    end
                    OP_ROR: begin
                        data_nxt  = {data_q[0], data_q[WIDTH-1:1]};
                        carry_nxt = data_q[0];
                    end
                    default: begin
                        // HOLD still spends one cycle per count.
                        data_nxt  = data_q;
                        carry_nxt = 1'b0;
                    end
                endcase
                count_nxt = count_q - ONE;
                if (count_q == ONE) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers. Reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state is cleared on reset and updated with non-blocking
        // assignments. Blocking ones here would race with other
        // clocked readers.
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_nxt;
            data_q  <= data_nxt;
            carry_q <= carry_nxt;
            count_q <= count_nxt;
            mode_q  <= mode_nxt;
        end
    end

    // All outputs come straight from registers, with no input-to-output path.
    assign bus.dout  = data_q;
    assign bus.carry = carry_q;
    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = (state_q == DONE);
endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq at WIDTH=16.
// Expected results are pushed to a scoreboard when a request is driven.
// They are popped and compared when done is observed.
module tb_shift_reg_seq;
    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] dout;
        logic        carry;
        int          cycles;
    } exp_t;

    typedef struct {
        logic [2:0]  m;
        logic [3:0]  a;
        logic [15:0] d;
        logic [15:0] ed;
        logic        ec;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    exp_t sb[$];

    // Directed vectors with hand-derived results.
    vec_t vecs [8] = '{
        '{3'b000, 4'd3,  16'h8001, 16'h0008, 1'b0},  // LSL by 3
        '{3'b000, 4'd1,  16'h8001, 16'h0002, 1'b1},  // LSL by 1
        '{3'b000, 4'd0,  16'hA5A5, 16'hA5A5, 1'b0},  // amt=0 clears carry
        '{3'b010, 4'd4,  16'h8000, 16'hF800, 1'b0},  // ASR by 4
        '{3'b001, 4'd4,  16'h8000, 16'h0800, 1'b0},  // LSR by 4
        '{3'b100, 4'd1,  16'h0001, 16'h8000, 1'b1},  // ROR by 1
        '{3'b110, 4'd5,  16'h1234, 16'h1234, 1'b0},  // HOLD
        '{3'b011, 4'd15, 16'h0001, 16'h8000, 1'b0}   // ROL by 15
    };

    shift_reg_seq_if #(.WIDTH(WIDTH)) bus ();

    shift_reg_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Closed-form reference for an amt-step operation.
    function automatic void model(input logic [2:0] m, input int a, input logic [15:0] d,
                                  output logic [15:0] r, output logic c);
        r = d;
        c = 1'b0;
        if (a == 0) return;
        case (m)
            3'b000: begin r = d << a; c = d[16-a]; end
            3'b001: begin r = d >> a; c = d[a-1]; end
            3'b010: begin r = 16'($signed(d) >>> a); c = d[a-1]; end
            3'b011: begin r = (d << a) | (d >> (16 - a)); c = r[0]; end
            3'b100: begin r = (d >> a) | (d << (16 - a)); c = r[15]; end
            default: begin r = d; c = 1'b0; end
        endcase
    endfunction

    // Drive a request for one accept edge and record its expected result.
    // Returns 1 time unit after the accept edge.
    task automatic start_op(input logic [2:0] m, input logic [3:0] a, input logic [15:0] d,
                            input bit keep, input logic [15:0] ed, input logic ec);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.amt   = a;
        bus.din   = d;
        sb.push_back('{ed, ec, int'(a)});
        @(posedge clk);
        #1;
        if (!keep) bus.start = 1'b0;
    endtask

    // Count cycles from the accept edge until done, bounded at 64.
    task automatic wait_done(output int cyc, output int busy_n,
                             output logic [15:0] d, output logic c);
        cyc    = 0;
        busy_n = 0;
        @(negedge clk);
        while (bus.done !== 1'b1 && cyc < 64) begin
            if (bus.busy === 1'b1) busy_n++;
            @(negedge clk);
            cyc++;
        end
        d = bus.dout;
        c = bus.carry;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.dout, bus.carry, bus.busy, bus.done} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_held: dout=%h carry=%b busy=%b done=%b, required all zero",
                     bus.dout, bus.carry, bus.busy, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.dout, bus.carry, bus.busy, bus.done} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_release: dout=%h carry=%b busy=%b done=%b, required all zero",
                     bus.dout, bus.carry, bus.busy, bus.done);
        end
    endtask

    task automatic test_shift_modes();
        int cyc, busy_n;
        logic [15:0] d;
        logic c;
        exp_t e;
        foreach (vecs[i]) begin
            start_op(vecs[i].m, vecs[i].a, vecs[i].d, 1'b0, vecs[i].ed, vecs[i].ec);
            wait_done(cyc, busy_n, d, c);
            e = sb.pop_front();
            tests_run++;
            if (d !== e.dout) begin
                tests_failed++;
                $display("FAIL mode%0d dout: got %h, required %h", i, d, e.dout);
            end
            tests_run++;
            if (c !== e.carry) begin
                tests_failed++;
                $display("FAIL mode%0d carry: got %b, required %b", i, c, e.carry);
            end
            tests_run++;
            if (cyc !== e.cycles) begin
                tests_failed++;
                $display("FAIL mode%0d latency: got %0d, required %0d", i, cyc, e.cycles);
            end
            tests_run++;
            if (busy_n !== e.cycles) begin
                tests_failed++;
                $display("FAIL mode%0d busy_cycles: got %0d, required %0d", i, busy_n, e.cycles);
            end
            @(negedge clk);
            tests_run++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL mode%0d done_width: done=%b busy=%b, required 0/0",
                         i, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_ignore_start();
        int cyc, busy_n;
        logic [15:0] d;
        logic c;
        exp_t e;
        start_op(3'b000, 4'd3, 16'h8001, 1'b0, 16'h0008, 1'b0);
        // Competing request while shifting.
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 3'b100;
        bus.amt   = 4'd7;
        bus.din   = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc, busy_n, d, c);
        e = sb.pop_front();
        tests_run++;
        if (d !== e.dout || c !== e.carry) begin
            tests_failed++;
            $display("FAIL ignore_start result: got %h/%b, required %h/%b", d, c, e.dout, e.carry);
        end
        tests_run++;
        if (cyc !== 2) begin
            tests_failed++;
            $display("FAIL ignore_start latency: got %0d, required 2", cyc);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_start done_width: done=%b busy=%b, required 0/0",
                     bus.done, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, busy_n;
        logic [15:0] d;
        logic c;
        exp_t e;
        start_op(3'b000, 4'd3, 16'h8001, 1'b1, 16'h0008, 1'b0);
        bus.mode = 3'b001;
        bus.amt  = 4'd4;
        bus.din  = 16'h00F0;
        sb.push_back('{16'h000F, 1'b0, 4});
        wait_done(cyc, busy_n, d, c);
        e = sb.pop_front();
        tests_run++;
        if (d !== e.dout || c !== e.carry || cyc !== e.cycles) begin
            tests_failed++;
            $display("FAIL b2b first: got %h/%b/%0d, required %h/%b/%0d",
                     d, c, cyc, e.dout, e.carry, e.cycles);
        end
        // start is still high in DONE, so this edge accepts the second op.
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b no_gap: busy=%b done=%b, required 1/0", bus.busy, bus.done);
        end
        wait_done(cyc, busy_n, d, c);
        e = sb.pop_front();
        tests_run++;
        if (d !== e.dout || c !== e.carry || cyc !== e.cycles) begin
            tests_failed++;
            $display("FAIL b2b second: got %h/%b/%0d, required %h/%b/%0d",
                     d, c, cyc, e.dout, e.carry, e.cycles);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b done_width: done=%b, required 0", bus.done);
        end
    endtask

    task automatic test_reset_mid_shift();
        int done_n, busy_n;
        start_op(3'b011, 4'd10, 16'hC003, 1'b0, 16'h0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.dout !== 16'h000F || bus.carry !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_shift pre: busy=%b dout=%h carry=%b, required 1/000f/1",
                     bus.busy, bus.dout, bus.carry);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.dout, bus.carry, bus.busy, bus.done} !== 19'd0) begin
            tests_failed++;
            $display("FAIL mid_shift async_clear: dout=%h carry=%b busy=%b done=%b, required all zero",
                     bus.dout, bus.carry, bus.busy, bus.done);
        end
        // The aborted operation never produces a result.
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        done_n = 0;
        busy_n = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.done !== 1'b0) done_n++;
            if (bus.busy !== 1'b0) busy_n++;
        end
        tests_run++;
        if (done_n !== 0 || busy_n !== 0) begin
            tests_failed++;
            $display("FAIL mid_shift after: done_cycles=%0d busy_cycles=%0d, required 0/0",
                     done_n, busy_n);
        end
    endtask

    task automatic test_random();
        int cyc, busy_n;
        logic [15:0] d, rd, ed;
        logic c, ec;
        logic [2:0] m;
        logic [3:0] a;
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            m  = 3'($urandom_range(0, 7));
            a  = 4'($urandom_range(0, 15));
            rd = 16'($urandom);
            model(m, int'(a), rd, ed, ec);
            start_op(m, a, rd, 1'b0, ed, ec);
            wait_done(cyc, busy_n, d, c);
            e = sb.pop_front();
            tests_run++;
            if (d !== e.dout || c !== e.carry || cyc !== e.cycles) begin
                tests_failed++;
                $display("FAIL random%0d m=%0d a=%0d din=%h: got %h/%b/%0d, required %h/%b/%0d",
                         i, m, a, rd, d, c, cyc, e.dout, e.carry, e.cycles);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.mode     = 3'b000;
        bus.amt      = '0;
        bus.din      = '0;

        test_reset();
        test_shift_modes();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
- Parametrised, multi-cycle shift/rotate unit. Successor to the fixed 16-bit shift-register datapath.
- Loads a WIDTH-bit word, applies one of five shift modes one bit position per clock for a programmed amount, then reports completion with a one-cycle done pulse.
- Sits between the operand source and the result sink of the shift-register datapath, and adds carry-out and rotate modes.

Parameters:
- WIDTH, 16, data word width; legal values are 2 and above.
- AMT_W, $clog2(WIDTH), localparam giving the width of the shift-amount field; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- mode  input  3  op select, sampled with start: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101–111 HOLD.
- amt  input  AMT_W  shift count, 0..WIDTH-1, sampled with start.
- din  input  WIDTH  operand, sampled with start.
- dout  output  WIDTH  working register, driven continuously; valid result while done=1.
- carry  output  1  last bit shifted or rotated out.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse while in DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, dout=0, carry=0, busy=0, done=0, count=0. A reset mid-operation aborts it immediately and the pending result is lost.
- States are IDLE, SHIFT and DONE. busy = (state==SHIFT). done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- IDLE or DONE with start=1 at an edge (the accept edge):
  - reg←din; latch mode; count←amt; carry←0.
  - Next state is SHIFT if amt≠0, else DONE.
- IDLE or DONE with start=0:
  - DONE→IDLE; IDLE stays IDLE.
  - Register and carry hold.
- SHIFT, at each edge:
  - Perform one 1-bit op on reg and update carry.
  - count←count-1.
  - If count==1 before the decrement, go to DONE; otherwise stay in SHIFT.
- start is ignored while in SHIFT. Mode, amount and operand are frozen for the whole operation.
- Latency: done is high in the cycle after edge E0+amt, where E0 is the accept edge. This gives amt+1 cycles from the start cycle. amt=0 gives done one cycle after start with dout=din and carry=0.
- Back-to-back: start asserted in DONE is accepted on that edge. done drops after one cycle and the new operation begins with no idle gap.
- 1-bit ops (N = WIDTH-1):
  - LSL: reg←{reg[N-1:0],0}, carry←reg[N].
  - LSR: reg←{0,reg[N:1]}, carry←reg[0].
  - ASR: reg←{reg[N],reg[N:1]}, carry←reg[0].
  - ROL: reg←{reg[N-1:0],reg[N]}, carry←reg[N].
  - ROR: reg←{reg[0],reg[N:1]}, carry←reg[0].
  - HOLD (101–111): reg unchanged, carry←0. Cycle timing is identical to a real shift.
- amt width is exactly AMT_W. WIDTH that is not a power of two is legal.
- When WIDTH is not a power of two, amt values ≥WIDTH are out of range. They still run amt cycles, so LSL/LSR can yield 0; the result is not checked.
- No combinational path from any input to any output.

Test Plan (WIDTH=16):
- Reset: assert rst_n=0 for 2 cycles, then release → dout=0x0000, carry=0, busy=0, done=0. Repeat with rst_n=0 asserted mid-SHIFT (amt=10, third shift cycle) → outputs clear asynchronously, state returns to IDLE, no done pulse.
- LSL: din=0x8001, amt=3 → busy high for 3 cycles, done in the 4th cycle after the start cycle, dout=0x0008, carry=0. With amt=1 → dout=0x0002, carry=1.
- ASR: din=0x8000, amt=4 → dout=0xF800, carry=0. LSR on the same inputs → dout=0x0800, carry=0.
- ROR: din=0x0001, amt=1 → dout=0x8000, carry=1. ROL: din=0x0001, amt=15 → dout=0x8000, carry=0, done 16 cycles after start.
- amt=0 with LSL, din=0xA5A5 → busy never high, done the next cycle, dout=0xA5A5, carry=0. Mode 110, amt=5, din=0x1234 → dout=0x1234, carry=0, done after 6 cycles.
- Handshake:
  - A start pulse during SHIFT with different din/mode is ignored and the first result is unchanged.
  - start held high through DONE launches a second op (LSR, din=0x00F0, amt=4 → 0x000F, carry=0) with no IDLE cycle between.
  - done is exactly 1 cycle wide in every case.
